step_sequencer: RTL

- Parametrised drum-pattern sequencer. Successor to the fixed 4-channel, 8-step instrument datapath.
- Holds NUM_CH per-channel step patterns, each STEPS bits wide, plus the BPM setting. All storage is synchronous registers, with no latches.
- Steps through a programmable loop length on each tick from the BPM divider. Emits per-channel trigger pulses and gate levels to the sound/LED stage.
- Pattern writes are double-buffered, so edits made while playing never glitch mid-bar.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_pattern_bank.sv | 48 ++++
 rtl/step_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, defaults and step-wrap helper for the step sequencer
package seq_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_STEPS  = 8;
    localparam int DEF_BPM_W  = 8;

    // A loop_last below the current step forces a wrap rather than running past it.
    function automatic logic [31:0] seq_next_step(input logic [31:0] cur, input logic [31:0] last);
        return (cur >= last) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/seq_pattern_bank.sv
// rtl/seq_pattern_bank.sv - double-buffered shadow/active pattern store with per-channel step bit select
module seq_pattern_bank
    import seq_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int STEPS  = DEF_STEPS,
    parameter int STEP_W = $clog2(DEF_STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ld_ch,
    input  logic [STEPS-1:0]  ld_data,
    input  logic              follow,
    input  logic              wrap,
    input  logic [STEP_W-1:0] sel_step,
    output logic [NUM_CH-1:0] step_bits
);

    logic [NUM_CH-1:0][STEPS-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0][STEPS-1:0] active_q, active_d;

    // Commit samples the pre-edge shadow, so a load landing on the wrap edge waits a bar.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        step_bits = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ld_ch[i]) begin
                shadow_d[i] = ld_data;
            end
            if (follow || wrap) begin
                active_d[i] = shadow_q[i];
            end
            step_bits[i] = wrap ? shadow_q[i][sel_step] : active_q[i][sel_step];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - drum-pattern sequencer top: run/pause/stop FSM, step counter and trigger outputs
module step_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int STEPS  = DEF_STEPS,
    parameter int BPM_W  = DEF_BPM_W,
    localparam int STEP_W = $clog2(STEPS),
    localparam int SEL_W  = (STEPS > BPM_W) ? STEPS : BPM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ld_ch,
    input  logic              ld_bpm,
    input  logic [SEL_W-1:0]  sel,
    input  logic [STEP_W-1:0] loop_last,
    input  logic [NUM_CH-1:0] mute,
    input  logic              tick,
    input  logic              play,
    input  logic              hold,
    output logic [BPM_W-1:0]  set_bpm,
    output logic [NUM_CH-1:0] trig,
    output logic [NUM_CH-1:0] gate,
    output logic [STEP_W-1:0] step_idx,
    output logic              bar_start,
    output logic              running
);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d, new_step;
    logic              first_q, first_d;
    logic [BPM_W-1:0]  bpm_q, bpm_d;
    logic [NUM_CH-1:0] trig_q, trig_d, gate_q, gate_d;
    logic              bar_q, bar_d;
    logic              advance, wrap, follow;
    logic [NUM_CH-1:0] step_bits;

    seq_pattern_bank #(
        .NUM_CH (NUM_CH),
        .STEPS  (STEPS),
        .STEP_W (STEP_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .ld_ch     (ld_ch),
        .ld_data   (sel[STEPS-1:0]),
        .follow    (follow),
        .wrap      (wrap),
        .sel_step  (new_step),
        .step_bits (step_bits)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP:  if (play && !hold) state_d = ST_RUN;
            ST_RUN:   if (hold)          state_d = ST_PAUSE;
            ST_PAUSE: if (!hold)         state_d = ST_RUN;
            default:                     state_d = ST_STOP;
        endcase
        if (!play) begin
            state_d = ST_STOP;
        end

        // The first tick after leaving STOP enters step 0 instead of advancing past it.
        advance  = (state_q == ST_RUN) && play && !hold && tick;
        new_step = first_q ? '0 : STEP_W'(seq_next_step(32'(step_q), 32'(loop_last)));
        wrap     = advance && (new_step == '0);
        follow   = (state_q != ST_RUN);

        step_d  = step_q;
        first_d = first_q;
        trig_d  = '0;
        bar_d   = 1'b0;
        gate_d  = gate_q & ~mute;
        if (!play) begin
            step_d  = '0;
            gate_d  = '0;
            first_d = 1'b1;
        end else if (advance) begin
            step_d  = new_step;
            first_d = 1'b0;
            trig_d  = step_bits & ~mute;
            gate_d  = step_bits & ~mute;
            bar_d   = (new_step == '0);
        end

        bpm_d = ld_bpm ? sel[BPM_W-1:0] : bpm_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
            step_q  <= '0;
            first_q <= 1'b1;
            bpm_q   <= '0;
            trig_q  <= '0;
            gate_q  <= '0;
            bar_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            first_q <= first_d;
            bpm_q   <= bpm_d;
            trig_q  <= trig_d;
            gate_q  <= gate_d;
            bar_q   <= bar_d;
        end
    end

    assign set_bpm   = bpm_q;
    assign trig      = trig_q;
    assign gate      = gate_q;
    assign step_idx  = step_q;
    assign bar_start = bar_q;
    assign running   = (state_q == ST_RUN);

endmodule
